// File: rtl/div_unit_if.sv
// Request/response bundle between the execute stage and the iterative divider.
// The core drives requests (master); the divider answers (slave).
interface div_unit_if #(
  parameter int XLEN = 32
) ();
  logic            i_start;
  logic            i_kill;
  logic [1:0]      i_divctl;
  logic [XLEN-1:0] i_op1;
  logic [XLEN-1:0] i_op2;
  logic            o_busy;
  logic            o_done;
  logic [XLEN-1:0] o_res;

  modport master (
    output i_start, i_kill, i_divctl, i_op1, i_op2,
    input  o_busy, o_done, o_res
  );

  modport slave (
    input  i_start, i_kill, i_divctl, i_op1, i_op2,
    output o_busy, o_done, o_res
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for RV32M div/divu/rem/remu, one quotient bit per cycle.
// Divide-by-zero and signed overflow skip the iteration and finish in one cycle.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_ctl;
  logic            r_neg1;
  logic            r_neg2;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_dvs;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_res;
  logic            r_busy;
  logic            r_done;

  logic            w_signed;
  logic            w_neg1;
  logic            w_neg2;
  logic [XLEN-1:0] w_abs1;
  logic [XLEN-1:0] w_abs2;
  logic            w_div0;
  logic            w_ovf;
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;
  logic [XLEN-1:0] w_qfix;
  logic [XLEN-1:0] w_rfix;

  assign w_signed = ~bus.i_divctl[0];
  assign w_neg1   = w_signed & bus.i_op1[XLEN-1];
  assign w_neg2   = w_signed & bus.i_op2[XLEN-1];
  assign w_abs1   = w_neg1 ? -bus.i_op1 : bus.i_op1;
  assign w_abs2   = w_neg2 ? -bus.i_op2 : bus.i_op2;
  assign w_div0   = (bus.i_op2 == '0);
  assign w_ovf    = w_signed && (bus.i_op1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.i_op2 == '1);

  // Trial subtraction is one bit wider than the operands so the borrow shows up as the sign.
  assign w_shift  = {r_rem, r_quo[XLEN-1]};
  assign w_diff   = w_shift - {1'b0, r_dvs};

  assign w_qfix   = (~r_ctl[0] & (r_neg1 ^ r_neg2)) ? -r_quo : r_quo;
  assign w_rfix   = (~r_ctl[0] & r_neg1) ? -r_rem : r_rem;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ctl   <= '0;
      r_neg1  <= 1'b0;
      r_neg2  <= 1'b0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_rem   <= '0;
      r_res   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (bus.i_kill) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.i_start) begin
            r_ctl  <= bus.i_divctl;
            r_neg1 <= w_neg1;
            r_neg2 <= w_neg2;
            r_busy <= 1'b1;
            if (w_div0) begin
              r_res   <= bus.i_divctl[1] ? bus.i_op1 : '1;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else if (w_ovf) begin
              r_res   <= bus.i_divctl[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_quo   <= w_abs1;
              r_dvs   <= w_abs2;
              r_rem   <= '0;
              r_cnt   <= '0;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (!w_diff[XLEN]) begin
            r_rem <= w_diff[XLEN-1:0];
            r_quo <= {r_quo[XLEN-2:0], 1'b1};
          end else begin
            r_rem <= w_shift[XLEN-1:0];
            r_quo <= {r_quo[XLEN-2:0], 1'b0};
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(XLEN-1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_res   <= r_ctl[1] ? w_rfix : w_qfix;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_busy = r_busy;
  assign bus.o_done = r_done;
  assign bus.o_res  = r_res;
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases, robustness scenarios and a random
// sweep compared against an arithmetic reference model.
module tb_div_unit;
  logic clk = 1'b0;
  logic rst;
  int   nChecks = 0;
  int   nFails  = 0;
  int   cycleCount = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycleCount <= cycleCount + 1;

  div_unit_if bus ();

  div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  logic        obsBusy [0:63];
  logic        obsDone [0:63];
  logic [31:0] obsRes  [0:63];
  int          opDoneCnt;
  int          opDoneCyc;
  logic [31:0] opRes;
  int          opStartAbs;

  // Reference: quotient truncates toward zero, remainder takes the dividend's sign.
  function automatic logic [31:0] model(input logic [1:0] ctl, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    if (b == 32'd0) return ctl[1] ? a : 32'hFFFFFFFF;
    if (!ctl[0]) begin
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) return ctl[1] ? 32'd0 : 32'h80000000;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return ctl[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return ctl[1] ? (a % b) : (a / b);
  endfunction

  function automatic int model_lat(input logic [1:0] ctl, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!ctl[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return 34;
  endfunction

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return 32'($urandom_range(0, 15));
      4:       return -32'($urandom_range(1, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // Drives one request (start in cycle 0) and records outputs at each negedge.
  // injKind: 0 none, 1 extra start, 2 kill, 3 reset -- asserted during cycle injCyc.
  task automatic do_op(input logic [1:0] ctl, input logic [31:0] a, input logic [31:0] b,
                       input int injCyc, input int injKind, input bit stopOnDone, input int maxc);
    int cyc;
    for (int i = 0; i < 64; i++) begin
      obsBusy[i] = 1'bx;
      obsDone[i] = 1'bx;
      obsRes[i]  = 'x;
    end
    opDoneCnt = 0;
    opDoneCyc = 0;
    opRes     = 'x;
    @(posedge clk); #1;
    bus.i_start  = 1'b1;
    bus.i_divctl = ctl;
    bus.i_op1    = a;
    bus.i_op2    = b;
    opStartAbs   = cycleCount;
    cyc = 0;
    while (cyc < maxc) begin
      @(negedge clk);
      obsBusy[cyc] = bus.o_busy;
      obsDone[cyc] = bus.o_done;
      obsRes[cyc]  = bus.o_res;
      if (cyc == 1) begin
        bus.i_start  = 1'b0;
        bus.i_divctl = 2'($urandom);
        bus.i_op1    = 32'($urandom);
        bus.i_op2    = 32'($urandom);
      end
      if (injKind != 0 && cyc == injCyc + 1) begin
        bus.i_start = 1'b0;
        bus.i_kill  = 1'b0;
        rst         = 1'b1;
      end
      if (injKind != 0 && cyc == injCyc) begin
        case (injKind)
          1: begin
            bus.i_start  = 1'b1;
            bus.i_divctl = 2'b01;
            bus.i_op1    = 32'd50;
            bus.i_op2    = 32'd5;
          end
          2:       bus.i_kill = 1'b1;
          default: rst = 1'b0;
        endcase
      end
      if (bus.o_done === 1'b1) begin
        opDoneCnt++;
        opDoneCyc = cyc;
        opRes     = bus.o_res;
        if (stopOnDone) break;
      end
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst          = 1'b0;
    bus.i_start  = 1'b0;
    bus.i_kill   = 1'b0;
    bus.i_divctl = 2'b00;
    bus.i_op1    = 32'd0;
    bus.i_op2    = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nChecks++;
    if (bus.o_busy !== 1'b0) begin nFails++; $display("[TB] FAIL reset_busy got %b want 0", bus.o_busy); end
    nChecks++;
    if (bus.o_done !== 1'b0) begin nFails++; $display("[TB] FAIL reset_done got %b want 0", bus.o_done); end
    nChecks++;
    if (bus.o_res !== 32'd0) begin nFails++; $display("[TB] FAIL reset_res got %h want 00000000", bus.o_res); end
    rst = 1'b1;
  endtask

  task automatic test_directed();
    vec_t v [6];
    int   bad;
    v = '{'{2'b00, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34},
          '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34},
          '{2'b01, 32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, 34},
          '{2'b11, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 34},
          '{2'b00, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 34},
          '{2'b10, 32'd100,      32'hFFFFFFF9, 32'h00000002, 34}};
    foreach (v[i]) begin
      do_op(v[i].ctl, v[i].a, v[i].b, 0, 0, 1, 40);
      bad = 0;
      for (int c = 1; c <= opDoneCyc && c < 64; c++) if (obsBusy[c] !== 1'b1) bad++;
      nChecks++;
      if (opRes !== v[i].exp) begin nFails++; $display("[TB] FAIL directed_res[%0d] got %h want %h", i, opRes, v[i].exp); end
      nChecks++;
      if (opDoneCyc !== v[i].lat) begin nFails++; $display("[TB] FAIL directed_lat[%0d] got %0d want %0d", i, opDoneCyc, v[i].lat); end
      nChecks++;
      if (opDoneCnt !== 1) begin nFails++; $display("[TB] FAIL directed_done_count[%0d] got %0d want 1", i, opDoneCnt); end
      nChecks++;
      if (bad !== 0 || obsBusy[0] !== 1'b0) begin nFails++; $display("[TB] FAIL directed_busy[%0d] got %0d low cycles, busy0=%b want 0,0", i, bad, obsBusy[0]); end
      @(negedge clk);
      nChecks++;
      if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 || bus.o_res !== v[i].exp) begin
        nFails++;
        $display("[TB] FAIL directed_after[%0d] got busy=%b done=%b res=%h want 0 0 %h", i, bus.o_busy, bus.o_done, bus.o_res, v[i].exp);
      end
    end
  endtask

  task automatic test_short_circuit();
    vec_t v [8];
    v = '{'{2'b00, 32'd1234,     32'd0,        32'hFFFFFFFF, 1},
          '{2'b01, 32'd1234,     32'd0,        32'hFFFFFFFF, 1},
          '{2'b10, 32'd1234,     32'd0,        32'h000004D2, 1},
          '{2'b11, 32'd1234,     32'd0,        32'h000004D2, 1},
          '{2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1},
          '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1},
          '{2'b01, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 34},
          '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34}};
    foreach (v[i]) begin
      do_op(v[i].ctl, v[i].a, v[i].b, 0, 0, 1, 40);
      nChecks++;
      if (opRes !== v[i].exp) begin nFails++; $display("[TB] FAIL short_res[%0d] got %h want %h", i, opRes, v[i].exp); end
      nChecks++;
      if (opDoneCyc !== v[i].lat || obsBusy[opDoneCyc] !== 1'b1) begin
        nFails++;
        $display("[TB] FAIL short_lat[%0d] got cycle %0d busy=%b want cycle %0d busy=1", i, opDoneCyc, obsBusy[opDoneCyc], v[i].lat);
      end
    end
  endtask

  task automatic test_start_ignored();
    int busyCnt = 0;
    do_op(2'b00, 32'hFFFFFFF9, 32'd2, 10, 1, 1, 40);
    nChecks++;
    if (opRes !== 32'hFFFFFFFD || opDoneCyc !== 34 || opDoneCnt !== 1) begin
      nFails++;
      $display("[TB] FAIL start_ignored got res=%h cyc=%0d n=%0d want FFFFFFFD 34 1", opRes, opDoneCyc, opDoneCnt);
    end
    repeat (4) begin
      @(negedge clk);
      if (bus.o_busy !== 1'b0) busyCnt++;
    end
    nChecks++;
    if (busyCnt !== 0) begin nFails++; $display("[TB] FAIL start_not_queued got %0d busy cycles want 0", busyCnt); end
  endtask

  task automatic test_kill();
    int doneCnt = 0;
    do_op(2'b01, 32'd100, 32'd7, 0, 0, 1, 40);
    nChecks++;
    if (opRes !== 32'd14) begin nFails++; $display("[TB] FAIL kill_setup got %h want 0000000e", opRes); end
    do_op(2'b00, 32'hFFFFFFF9, 32'd2, 15, 2, 0, 40);
    nChecks++;
    if (obsBusy[15] !== 1'b1 || obsBusy[16] !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL kill_busy got c15=%b c16=%b want 1 0", obsBusy[15], obsBusy[16]);
    end
    nChecks++;
    if (opDoneCnt !== 0) begin nFails++; $display("[TB] FAIL kill_no_done got %0d want 0", opDoneCnt); end
    nChecks++;
    if (obsRes[16] !== 32'd14 || obsRes[39] !== 32'd14) begin
      nFails++;
      $display("[TB] FAIL kill_res_held got %h/%h want 0000000e", obsRes[16], obsRes[39]);
    end
    // Kill and start in the same idle cycle: the start is dropped.
    @(posedge clk); #1;
    bus.i_start = 1'b1; bus.i_kill = 1'b1; bus.i_divctl = 2'b01; bus.i_op1 = 32'd9; bus.i_op2 = 32'd3;
    @(posedge clk); #1;
    bus.i_start = 1'b0; bus.i_kill = 1'b0;
    repeat (36) begin
      @(negedge clk);
      if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) doneCnt++;
    end
    nChecks++;
    if (doneCnt !== 0 || bus.o_res !== 32'd14) begin
      nFails++;
      $display("[TB] FAIL kill_beats_start got %0d active cycles res=%h want 0 0000000e", doneCnt, bus.o_res);
    end
    do_op(2'b11, 32'd100, 32'd7, 34, 2, 1, 40);
    @(posedge clk); #1;
    bus.i_kill = 1'b0;
    nChecks++;
    if (opDoneCnt !== 1 || opRes !== 32'd2) begin
      nFails++;
      $display("[TB] FAIL kill_in_done got n=%0d res=%h want 1 00000002", opDoneCnt, opRes);
    end
  endtask

  task automatic test_reset_midop();
    do_op(2'b00, 32'd100, 32'hFFFFFFF9, 20, 3, 0, 24);
    nChecks++;
    if (obsBusy[20] !== 1'b1 || obsBusy[21] !== 1'b0 || obsDone[21] !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL reset_mid_ctl got busy20=%b busy21=%b done21=%b want 1 0 0", obsBusy[20], obsBusy[21], obsDone[21]);
    end
    nChecks++;
    if (obsRes[21] !== 32'd0 || opDoneCnt !== 0) begin
      nFails++;
      $display("[TB] FAIL reset_mid_res got res=%h n=%0d want 00000000 0", obsRes[21], opDoneCnt);
    end
    do_op(2'b01, 32'hFFFFFFFF, 32'h10, 0, 0, 1, 40);
    nChecks++;
    if (opRes !== 32'h0FFFFFFF || opDoneCyc !== 34) begin
      nFails++;
      $display("[TB] FAIL reset_recover got res=%h cyc=%0d want 0fffffff 34", opRes, opDoneCyc);
    end
  endtask

  task automatic test_back_to_back();
    int          startA;
    logic [31:0] resA;
    do_op(2'b10, 32'd100, 32'hFFFFFFF9, 0, 0, 1, 40);
    startA = opStartAbs;
    resA   = opRes;
    do_op(2'b00, 32'd100, 32'hFFFFFFF9, 0, 0, 1, 40);
    nChecks++;
    if (resA !== 32'd2 || opRes !== 32'hFFFFFFF2) begin
      nFails++;
      $display("[TB] FAIL b2b_res got %h/%h want 00000002/fffffff2", resA, opRes);
    end
    nChecks++;
    if (opStartAbs - startA !== 35 || opStartAbs + opDoneCyc - startA !== 69 || opDoneCnt !== 1) begin
      nFails++;
      $display("[TB] FAIL b2b_timing got start %0d done %0d want 35 69", opStartAbs - startA, opStartAbs + opDoneCyc - startA);
    end
  endtask

  task automatic test_random();
    logic [1:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    for (int i = 0; i < 1200; i++) begin
      ctl = 2'($urandom_range(0, 3));
      a   = rnd_op();
      b   = rnd_op();
      exp = model(ctl, a, b);
      lat = model_lat(ctl, a, b);
      do_op(ctl, a, b, 0, 0, 1, 40);
      nChecks++;
      if (opRes !== exp) begin
        nFails++;
        $display("[TB] FAIL random_res ctl=%b a=%h b=%h got %h want %h", ctl, a, b, opRes, exp);
      end
      nChecks++;
      if (opDoneCyc !== lat || opDoneCnt !== 1) begin
        nFails++;
        $display("[TB] FAIL random_lat ctl=%b a=%h b=%h got %0d want %0d", ctl, a, b, opDoneCyc, lat);
      end
    end
  endtask

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog expired got no finish want finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_short_circuit();
    test_start_ignored();
    test_kill();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
